// File: rtl/lsu_wbu.sv
// lsu_wbu: load/store and writeback stage of the multi-cycle RV32 core.
// Accepts one execute result per transaction, issues at most one memory
// request (aligned strobes, lane-replicated store data), formats load data
// and retires with a one-cycle done pulse plus register-file write.
// Optional build macro: LSU_TIMEOUT_EN adds a response-wait timeout that
// retires the access with err=1 after TIMEOUT_CYCLES cycles in RESP.
module lsu_wbu #(
    parameter int unsigned WIDTH = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] exu_result,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       wb_sel,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic [4:0]       rd_addr,
    input  logic             rd_wen,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    output logic             mem_req_wen,
    output logic [WIDTH-1:0] mem_req_wdata,
    output logic [3:0]       mem_req_wstrb,
    input  logic             mem_resp_valid,
    input  logic [WIDTH-1:0] mem_resp_rdata,
    input  logic             mem_resp_err,
    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             done,
    output logic             err
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e         state_q, state_d;

    // Registered outputs
    logic           in_ready_q, in_ready_d;
    logic           req_valid_q, req_valid_d;
    logic [W-1:0]   req_addr_q, req_addr_d;
    logic           req_wen_q, req_wen_d;
    logic [W-1:0]   req_wdata_q, req_wdata_d;
    logic [3:0]     req_wstrb_q, req_wstrb_d;
    logic           rf_wen_q, rf_wen_d;
    logic [4:0]     rf_waddr_q, rf_waddr_d;
    logic [W-1:0]   rf_wdata_q, rf_wdata_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    // Transaction context held across the memory access
    logic [W-1:0]   alu_q, alu_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [1:0]     wb_sel_q, wb_sel_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [1:0]     lane_q, lane_d;
    logic [4:0]     rd_q, rd_d;
    logic           rd_wen_q, rd_wen_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic           is_mem;
    logic           illegal;
    logic [W-1:0]   load_val;

    // Writeback source mux; the reserved encoding behaves as the ALU result
    function automatic logic [W-1:0] wb_mux(input logic [1:0] sel, input logic [W-1:0] alu,
                                            input logic [W-1:0] pcv, input logic [W-1:0] ld);
        logic [W-1:0] r;
        case (sel)
            2'b01:   r = ld;
            2'b10:   r = pcv + W'(4);
            default: r = alu;
        endcase
        return r;
    endfunction

    // Access legality decode and load-data lane extraction with extension
    always_comb begin
        is_mem  = mem_ren | mem_wen;
        illegal = is_mem & ((mem_size == 2'b11) ||
                            ((mem_size == 2'b01) && exu_result[0]) ||
                            ((mem_size == 2'b10) && (exu_result[1:0] != 2'b00)));
        load_val = mem_resp_rdata;
        case (size_q)
            2'b00: begin
                logic [7:0] b;
                b = 8'(mem_resp_rdata >> {lane_q, 3'b000});
                load_val = uns_q ? W'(b) : {{(W-8){b[7]}}, b};
            end
            2'b01: begin
                logic [15:0] h;
                h = lane_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
                load_val = uns_q ? W'(h) : {{(W-16){h[15]}}, h};
            end
            default: load_val = mem_resp_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        rf_wen_d    = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        alu_d       = alu_q;
        pc_d        = pc_q;
        wb_sel_d    = wb_sel_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        rd_wen_d    = rd_wen_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    alu_d    = exu_result;
                    pc_d     = pc;
                    wb_sel_d = wb_sel;
                    size_d   = mem_size;
                    uns_d    = mem_unsigned;
                    lane_d   = exu_result[1:0];
                    rd_d     = rd_addr;
                    rd_wen_d = rd_wen;
                    if (is_mem && !illegal) begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = {exu_result[W-1:2], 2'b00};
                        req_wen_d   = mem_wen;
                        case (mem_size)
                            2'b00: begin
                                req_wdata_d = {4{rs2_data[7:0]}};
                                req_wstrb_d = 4'(4'b0001 << exu_result[1:0]);
                            end
                            2'b01: begin
                                req_wdata_d = {2{rs2_data[15:0]}};
                                req_wstrb_d = 4'(4'b0011 << exu_result[1:0]);
                            end
                            default: begin
                                req_wdata_d = rs2_data;
                                req_wstrb_d = 4'b1111;
                            end
                        endcase
                        if (!mem_wen) begin
                            req_wstrb_d = 4'b0000;
                        end
                    end else begin
                        state_d    = S_WB;
                        done_d     = 1'b1;
                        err_d      = illegal;
                        rf_wen_d   = rd_wen & (rd_addr != 5'd0) & ~illegal;
                        rf_waddr_d = rd_addr;
                        rf_wdata_d = wb_mux(wb_sel, exu_result, pc, W'(0));
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d     = S_RESP;
                    req_valid_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_RESP: begin
                if (mem_resp_valid) begin
                    state_d    = S_WB;
                    done_d     = 1'b1;
                    err_d      = mem_resp_err;
                    rf_wen_d   = rd_wen_q & (rd_q != 5'd0) & ~mem_resp_err;
                    rf_waddr_d = rd_q;
                    rf_wdata_d = wb_mux(wb_sel_q, alu_q, pc_q, load_val);
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_WB;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    rf_waddr_d = rd_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            alu_q       <= '0;
            pc_q        <= '0;
            wb_sel_q    <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            alu_q       <= alu_d;
            pc_q        <= pc_d;
            wb_sel_q    <= wb_sel_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            rd_wen_q    <= rd_wen_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wstrb = req_wstrb_q;
    assign rf_wen        = rf_wen_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_lsu_wbu.sv
// tb_lsu_wbu: directed vector bench for lsu_wbu with a small memory responder.
module tb_lsu_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] exu_result, rs2_data, pc;
    logic [1:0]  wb_sel;
    logic        mem_ren, mem_wen;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_wbu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .exu_result(exu_result), .rs2_data(rs2_data), .pc(pc), .wb_sel(wb_sel),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .rd_addr(rd_addr), .rd_wen(rd_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .done(done), .err(err)
    );

    typedef struct {
        string       nm;
        logic [31:0] exu, rs2, pcv;
        logic [1:0]  sel;
        logic        ren, wen;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        rdw;
        int          rq_wait, rs_wait;
        logic [31:0] rdata;
        logic        rerr;
        logic        e_mem;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic        e_rfw;
        logic [31:0] e_rfd;
        logic        e_err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, ".req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({nm, ".done"}, 32'(done), 32'd0);
        chk({nm, ".rf_wen"}, 32'(rf_wen), 32'd0);
        chk({nm, ".err"}, 32'(err), 32'd0);
    endtask

    task automatic drive(input vec_t v);
        exu_result = v.exu; rs2_data = v.rs2; pc = v.pcv; wb_sel = v.sel;
        mem_ren = v.ren; mem_wen = v.wen; mem_size = v.size; mem_unsigned = v.uns;
        rd_addr = v.rd; rd_wen = v.rdw; in_valid = 1'b1;
    endtask

    // One complete transaction with a cooperating memory responder
    task automatic do_txn(input vec_t v);
        chk({v.nm, ".in_ready"}, 32'(in_ready), 32'd1);
        drive(v);
        tick();
        in_valid = 1'b0;
        if (v.e_mem) begin
            for (int i = 0; i <= v.rq_wait; i++) begin
                if (i > 0) tick();
                chk({v.nm, ".req_valid"}, 32'(mem_req_valid), 32'd1);
                chk({v.nm, ".req_addr"}, mem_req_addr, v.e_addr);
                chk({v.nm, ".req_wen"}, 32'(mem_req_wen), 32'(v.wen));
                chk({v.nm, ".req_wstrb"}, 32'(mem_req_wstrb), 32'(v.e_strb));
                if (v.wen) chk({v.nm, ".req_wdata"}, mem_req_wdata, v.e_wdata);
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk({v.nm, ".req_drop"}, 32'(mem_req_valid), 32'd0);
            for (int i = 0; i < v.rs_wait; i++) tick();
            mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata; mem_resp_err = v.rerr;
            tick();
            mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
        end else begin
            chk({v.nm, ".no_req"}, 32'(mem_req_valid), 32'd0);
        end
        chk({v.nm, ".done"}, 32'(done), 32'd1);
        chk({v.nm, ".err"}, 32'(err), 32'(v.e_err));
        chk({v.nm, ".rf_wen"}, 32'(rf_wen), 32'(v.e_rfw));
        if (v.e_rfw) begin
            chk({v.nm, ".rf_waddr"}, 32'(rf_waddr), 32'(v.rd));
            chk({v.nm, ".rf_wdata"}, rf_wdata, v.e_rfd);
        end
        tick();
        chk({v.nm, ".done_end"}, 32'(done), 32'd0);
        chk({v.nm, ".ready_end"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        //         nm          exu           rs2           pc            sel   ren   wen   size  uns   rd     rdw  rqw rsw rdata         rerr  e_mem e_addr        e_wdata       e_strb   e_rfw e_rfd         e_err
        vecs[0]  = '{"alu",    32'h12345678, 32'h0,        32'h00001000, 2'b00,1'b0, 1'b0, 2'd2, 1'b0, 5'd5,  1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b1, 32'h12345678, 1'b0};
        vecs[1]  = '{"jal_wrap",32'h0,       32'h0,        32'hFFFFFFFC, 2'b10,1'b0, 1'b0, 2'd2, 1'b0, 5'd1,  1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b1, 32'h00000000, 1'b0};
        vecs[2]  = '{"jal_rd0",32'h0,        32'h0,        32'h00000100, 2'b10,1'b0, 1'b0, 2'd2, 1'b0, 5'd0,  1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{"lb",     32'h80000003, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd0, 1'b0, 5'd7,  1'b1, 0, 1, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h0,        4'b0000, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[4]  = '{"lbu",    32'h80000003, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd0, 1'b1, 5'd7,  1'b1, 0, 1, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h0,        4'b0000, 1'b1, 32'h00000080, 1'b0};
        vecs[5]  = '{"lh",     32'h80000002, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd1, 1'b0, 5'd8,  1'b1, 0, 0, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h0,        4'b0000, 1'b1, 32'hFFFF80AA, 1'b0};
        vecs[6]  = '{"lhu",    32'h80000000, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd1, 1'b1, 5'd9,  1'b1, 0, 0, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h0,        4'b0000, 1'b1, 32'h0000BBCC, 1'b0};
        vecs[7]  = '{"lw",     32'h80000004, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd2, 1'b0, 5'd10, 1'b1, 1, 2, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000004, 32'h0,        4'b0000, 1'b1, 32'h80AABBCC, 1'b0};
        vecs[8]  = '{"lb_pos", 32'h00000401, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd0, 1'b0, 5'd11, 1'b1, 0, 0, 32'h00007F00, 1'b0, 1'b1, 32'h00000400, 32'h0,        4'b0000, 1'b1, 32'h0000007F, 1'b0};
        vecs[9]  = '{"sb",     32'h80000001, 32'h000000A5, 32'h0,        2'b00,1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  1'b0, 3, 1, 32'h0,        1'b0, 1'b1, 32'h80000000, 32'hA5A5A5A5, 4'b0010, 1'b0, 32'h0,        1'b0};
        vecs[10] = '{"sh",     32'h10000002, 32'h1234BEEF, 32'h0,        2'b00,1'b0, 1'b1, 2'd1, 1'b0, 5'd0,  1'b0, 0, 0, 32'h0,        1'b0, 1'b1, 32'h10000000, 32'hBEEFBEEF, 4'b1100, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{"sw",     32'h10000008, 32'hDEADBEEF, 32'h0,        2'b00,1'b0, 1'b1, 2'd2, 1'b0, 5'd0,  1'b0, 1, 0, 32'h0,        1'b0, 1'b1, 32'h10000008, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{"lw_mis", 32'h80000002, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd2, 1'b0, 5'd3,  1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{"lh_odd", 32'h80000001, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd1, 1'b0, 5'd3,  1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1'b1};
        vecs[14] = '{"ld_sz3", 32'h80000000, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd3, 1'b0, 5'd3,  1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1'b1};
        vecs[15] = '{"st_sz3", 32'h80000000, 32'h11223344, 32'h0,        2'b00,1'b0, 1'b1, 2'd3, 1'b0, 5'd0,  1'b0, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        1'b1};
        vecs[16] = '{"ld_berr",32'h80000008, 32'h0,        32'h0,        2'b01,1'b1, 1'b0, 2'd2, 1'b0, 5'd4,  1'b1, 0, 1, 32'h55555555, 1'b1, 1'b1, 32'h80000008, 32'h0,        4'b0000, 1'b0, 32'h0,        1'b1};
        vecs[17] = '{"sel11",  32'hCAFEF00D, 32'h0,        32'h00000040, 2'b11,1'b0, 1'b0, 2'd0, 1'b0, 5'd31, 1'b1, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[18] = '{"sb_ln3", 32'h00000023, 32'h0000005A, 32'h0,        2'b00,1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  1'b0, 0, 0, 32'h0,        1'b0, 1'b1, 32'h00000020, 32'h5A5A5A5A, 4'b1000, 1'b0, 32'h0,        1'b0};

        rst_n = 1'b0; in_valid = 1'b0; exu_result = '0; rs2_data = '0; pc = '0;
        wb_sel = '0; mem_ren = 1'b0; mem_wen = 1'b0; mem_size = '0; mem_unsigned = 1'b0;
        rd_addr = '0; rd_wen = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = '0; mem_resp_err = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        chk("reset.req_wstrb", 32'(mem_req_wstrb), 32'd0);
        chk("reset.rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        // Stale response while idle must not retire anything
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("stale.done", 32'(done), 32'd0);
        chk("stale.ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 19; i++) do_txn(vecs[i]);

        // A response coinciding with the request handshake is not taken
        drive(vecs[7]);
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0BAD0;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        chk("same_cyc.done", 32'(done), 32'd0);
        tick();
        chk("same_cyc.wait", 32'(done), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BADF00D;
        tick();
        mem_resp_valid = 1'b0;
        chk("same_cyc.done2", 32'(done), 32'd1);
        chk("same_cyc.rf_wdata", rf_wdata, 32'h0BADF00D);
        tick();

        // Asynchronous reset in RESP abandons the access
        drive(vecs[3]);
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h80AABBCC;
        tick();
        tick();
        mem_resp_valid = 1'b0;
        chk("rst_resp.late_done", 32'(done), 32'd0);
        chk("rst_resp.late_rfw", 32'(rf_wen), 32'd0);
        chk("rst_resp.ready", 32'(in_ready), 32'd1);

        // Back-to-back ALU ops retire every second cycle
        drive(vecs[0]);
        tick();
        chk("b2b.done1", 32'(done), 32'd1);
        chk("b2b.busy", 32'(in_ready), 32'd0);
        tick();
        chk("b2b.gap", 32'(done), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b2b.done2", 32'(done), 32'd1);
        chk("b2b.wdata2", rf_wdata, 32'h12345678);
        tick();

`ifdef LSU_TIMEOUT_EN
        // No response: retire with error after the timeout window
        begin
            int k;
            drive(vecs[7]);
            tick();
            in_valid = 1'b0;
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            k = 0;
            while (!done && k < 2000) begin
                tick();
                k++;
            end
            chk("tmo.cycles", 32'(k), 32'd255);
            chk("tmo.err", 32'(err), 32'd1);
            chk("tmo.rf_wen", 32'(rf_wen), 32'd0);
            tick();
            mem_resp_valid = 1'b1;
            tick();
            mem_resp_valid = 1'b0;
            chk("tmo.late", 32'(done), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_wbu.md
Name: lsu_wbu

Overview:
- Consumer-side partner of the execute stage in the multi-cycle RV32 core.
- Accepts one execute result per transaction over a valid/ready handshake.
- For loads and stores, issues a single memory request with aligned byte strobes and waits for the response; formats load data with sign or zero extension.
- Writes the selected value to the register file and pulses done, which the IFU uses to fetch the next instruction.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the lane logic assumes 4 byte lanes.
- TIMEOUT_CYCLES, 255, response-wait limit. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  execute result valid
- in_ready  out  1  block idle and able to accept
- exu_result  in  WIDTH  ALU result; the memory address for loads and stores
- rs2_data  in  WIDTH  store data
- pc  in  WIDTH  instruction PC
- wb_sel  in  2  00 ALU result, 01 load data, 10 pc+4, 11 reserved (treated as 00)
- mem_ren  in  1  load
- mem_wen  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_unsigned  in  1  zero-extend the load
- rd_addr  in  5  destination register
- rd_wen  in  1  instruction writes rd
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  WIDTH  lane-replicated store data
- mem_req_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  response valid
- mem_resp_rdata  in  WIDTH  read data
- mem_resp_err  in  1  bus error
- rf_wen  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  WIDTH  register file write data
- done  out  1  one-cycle retire pulse
- err  out  1  sticky-per-instruction error flag, valid while done=1

Behaviour:
- Reset values: state IDLE; all outputs 0 except in_ready=1; all captured registers 0.
- Reset is asynchronous and may assert in any state. An in-flight request or response is abandoned.
- State machine: IDLE, REQ, RESP, WB.
- IDLE:
  - in_ready=1.
  - On in_valid, capture all inputs.
  - If (mem_ren|mem_wen) and the access is legal, go to REQ; otherwise go to WB.
  - mem_resp_valid is ignored in IDLE, including stale responses after reset.
- Illegal access: mem_size=11; half with addr[0]=1; word with addr[1:0]!=0.
  - Go directly to WB with err=1.
  - No memory request is issued and no register write occurs.
- REQ:
  - mem_req_valid=1. All mem_req_* outputs stay stable until mem_req_ready=1.
  - On the handshake edge, go to RESP. mem_req_valid drops in the next cycle.
  - A response arriving in the same cycle as the request handshake is not accepted.
- RESP:
  - Wait for mem_resp_valid. Stores also wait for the response.
  - Capture rdata and mem_resp_err, then go to WB.
- WB:
  - Lasts exactly one cycle; done=1; then return to IDLE.
  - rf_wen = rd_wen & (rd_addr!=0) & !err.
  - rf_waddr = rd_addr.
  - rf_wdata is selected by wb_sel.
- Store lanes, with lane = addr[1:0]:
  - byte: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001<<lane
  - half: wdata = {2{rs2[15:0]}}, wstrb = 4'b0011<<lane
  - word: wdata = rs2, wstrb = 4'b1111
  - loads: wstrb = 0
- Load formatting:
  - Select the byte or half at lane from rdata.
  - Sign-extend unless mem_unsigned=1.
  - Word loads pass rdata unchanged.
- pc+4 is computed with modulo-2^32 wrap (0xFFFFFFFC gives 0).
- Latency:
  - Non-memory: accept edge, then WB cycle; rf_wen/done in the cycle after accept. Throughput is one instruction per 2 cycles.
  - Memory: 1 (REQ) + request wait + response wait + 1 (WB).

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on entry to RESP and increments each cycle in RESP.
  - When the counter reaches TIMEOUT_CYCLES without mem_resp_valid, go to WB with err=1 and no register write.
  - A late response arriving in IDLE is ignored.
- When undefined: the counter logic is absent and RESP waits indefinitely.

Test Plan:
- ALU op: exu_result=0x12345678, wb_sel=00, rd=5 -> the cycle after accept: rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, done=1, err=0; in_ready returns to 1 the next cycle.
- JAL writeback: pc=0xFFFFFFFC, wb_sel=10, rd=1 -> rf_wdata=0x00000000. Then rd=0 -> rf_wen=0 and done=1.
- lb: addr=0x80000003, rdata=0x80AABBCC -> rf_wdata=0xFFFFFF80. lbu at the same address -> 0x00000080. lh at addr 0x80000002 -> 0xFFFF80AA.
- sb: addr=0x80000001, rs2=0x000000A5, mem_req_ready held low 3 cycles -> mem_req_* stable throughout; wdata=0xA5A5A5A5, wstrb=0010, addr=0x80000000, mem_req_wen=1; after the response, done=1 and rf_wen=0.
- Misaligned lw at addr=0x80000002 -> mem_req_valid never asserts; next cycle done=1, err=1, rf_wen=0. mem_resp_err=1 on a legal load -> err=1, no write.
- rst_n pulsed low while in RESP -> outputs return to reset values immediately; a subsequent mem_resp_valid is ignored. With LSU_TIMEOUT_EN and no response -> err=1 and done after TIMEOUT_CYCLES cycles in RESP.
